// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - write/read handshake bundle for sync_fifo
// Ports (signals):
//   data_i, s_valid_i / s_ready_o : producer side (payload, request, accept)
//   data_o, m_valid_o / m_ready_i : consumer side (head payload, valid, take)
// Modports:
//   slave  : the FIFO itself
//   master : the agent driving writes and taking reads
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_i;
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  m_valid_o;
    logic                  m_ready_i;

    modport slave (
        input  data_i,
        input  s_valid_i,
        output s_ready_o,
        output data_o,
        output m_valid_o,
        input  m_ready_i
    );

    modport master (
        output data_i,
        output s_valid_i,
        input  s_ready_o,
        input  data_o,
        input  m_valid_o,
        output m_ready_i
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with optional registered output stage
// Ports:
//   clk            : clock, rising edge
//   rst_n          : synchronous active-low reset
//   flush_i        : synchronous clear, present only with SYNC_FIFO_FLUSH_EN
//   bus            : sync_fifo_if.slave (write and read handshakes)
//   count_o        : entries held, memory plus output stage
//   empty_o, full_o, almost_empty_o, almost_full_o : registered-state flags
// Optional feature macro: SYNC_FIFO_FLUSH_EN
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int AE_THRESH  = 1,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int OUT_REG    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef SYNC_FIFO_FLUSH_EN
    input  logic                          flush_i,
`endif
    sync_fifo_if.slave                    bus,
    output logic [$clog2(FIFO_DEPTH)+1:0] count_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic                          almost_empty_o,
    output logic                          almost_full_o
);
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH  = ADDR_WIDTH + 2;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [CNT_WIDTH-1:0]  count_q;

    logic mem_empty;
    logic mem_full;
    logic wr_en;      // accepted write
    logic rd_en;      // accepted read at the consumer interface
    logic mem_pop;    // memory head leaves memory (to consumer or output stage)
    logic mem_we;

    // Extra pointer bit distinguishes full from empty when low bits match.
    assign mem_empty = (wr_ptr == rd_ptr);
    assign mem_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                       (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    // Ready depends only on registered state, so a same-cycle read never
    // frees a slot for a write into a full memory.
    assign bus.s_ready_o = !mem_full;
    assign wr_en         = bus.s_valid_i && !mem_full;

`ifdef SYNC_FIFO_FLUSH_EN
    assign mem_we = wr_en && !flush_i;
`else
    assign mem_we = wr_en;
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_i;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_fwft
            // Head of memory is presented directly.
            assign bus.m_valid_o = !mem_empty;
            assign bus.data_o    = mem[rd_ptr[ADDR_WIDTH-1:0]];
            assign rd_en         = !mem_empty && bus.m_ready_i;
            assign mem_pop       = rd_en;
        end else begin : g_oreg
            logic                  out_valid;
            logic [DATA_WIDTH-1:0] out_data;

            assign bus.m_valid_o = out_valid;
            assign bus.data_o    = out_data;
            assign rd_en         = out_valid && bus.m_ready_i;
            // Refill the stage when it is empty or being drained this cycle.
            assign mem_pop       = !mem_empty && (!out_valid || rd_en);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end
`ifdef SYNC_FIFO_FLUSH_EN
                else if (flush_i) begin
                    out_valid <= 1'b0;
                end
`endif
                else if (mem_pop) begin
                    out_valid <= 1'b1;
                    out_data  <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                end else if (rd_en) begin
                    out_valid <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end
`ifdef SYNC_FIFO_FLUSH_EN
        else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end
`endif
        else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mem_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_q <= count_q + 1'b1;
            end else if (rd_en && !wr_en) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign count_o        = count_q;
    assign full_o         = mem_full;
    assign empty_o        = (count_q == '0);
    assign almost_empty_o = (count_q <= CNT_WIDTH'(AE_THRESH));
    assign almost_full_o  = (count_q >= CNT_WIDTH'(AF_THRESH));
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, memory entries; power of two, >= 4.
REQ-003 SHALL have parameter AE_THRESH, default 1, almost-empty level in entries.
REQ-004 SHALL have parameter AF_THRESH, default FIFO_DEPTH-1, almost-full level in entries.
REQ-005 SHALL have parameter OUT_REG, default 0: 0 = first-word-fall-through from memory; 1 = registered output stage.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port data_i, input, DATA_WIDTH bits: write payload.
REQ-009 SHALL have port s_valid_i, input, 1 bit: write request.
REQ-010 SHALL have port s_ready_o, output, 1 bit: write can be accepted.
REQ-011 SHALL have port data_o, output, DATA_WIDTH bits: head payload.
REQ-012 SHALL have port m_valid_o, output, 1 bit: data_o holds a valid entry.
REQ-013 SHALL have port m_ready_i, input, 1 bit: consumer takes head.
REQ-014 SHALL have port count_o, output, $clog2(FIFO_DEPTH)+2 bits: entries held (memory plus output stage).
REQ-015 SHALL have outputs empty_o, full_o, almost_empty_o, almost_full_o, 1 bit each.

Function
REQ-016 Write accepted on a cycle with s_valid_i & s_ready_o; s_ready_o = !full_o; full_o = memory holds FIFO_DEPTH entries.
REQ-017 Read accepted on a cycle with m_valid_o & m_ready_i; data_o not sampled by consumer when m_valid_o=0 (value don't-care).
REQ-018 Pointers ADDR_WIDTH+1 bits, wrap modulo 2*FIFO_DEPTH; MSB difference with equal low bits = memory full, fully equal = memory empty.
REQ-019 OUT_REG=0: m_valid_o = memory non-empty, data_o = memory[rd_ptr] combinationally; write into empty FIFO at edge N gives m_valid_o=1 in cycle N+1.
REQ-020 OUT_REG=1: output register loads memory head whenever it is empty or being read that cycle and memory non-empty; write into empty FIFO at edge N gives m_valid_o=1 in cycle N+2; total capacity FIFO_DEPTH+1.
REQ-021 Simultaneous read and write when neither full nor empty: both accepted, count_o unchanged.
REQ-022 Write while full_o=1: not accepted, no pointer or memory change, even if a read occurs that cycle (no pass-through).
REQ-023 Read while m_valid_o=0: ignored, no pointer change.
REQ-024 count_o += 1 on accepted write only, -= 1 on accepted read only; never exceeds FIFO_DEPTH+OUT_REG, never below 0.
REQ-025 empty_o = (count_o == 0); almost_empty_o = (count_o <= AE_THRESH); almost_full_o = (count_o >= AF_THRESH); all derived from registered state, no combinational path from s_valid_i/m_ready_i.
REQ-026 Data order strictly FIFO across pointer wrap-around; no entry lost or duplicated.

Reset
REQ-027 While rst_n=0 at a rising edge: pointers, count_o, output-stage valid cleared; outputs then s_ready_o=1, m_valid_o=0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0.
REQ-028 Memory array not reset; output data register reset to 0 when OUT_REG=1.
REQ-029 Reset asserted mid-operation discards all held entries; first post-reset write behaves as into empty FIFO.

Configuration
REQ-030 Macro SYNC_FIFO_FLUSH_EN defined: extra input flush_i (1 bit); flush_i=1 at an edge clears pointers, count_o, output-stage valid exactly as reset, ignoring any write or read that cycle; memory untouched.
REQ-031 Macro SYNC_FIFO_FLUSH_EN undefined: no flush_i port, no flush logic; all other behaviour identical.

Verification
REQ-032 Defaults, OUT_REG=0: write 32 words 0x00..0x1F back-to-back -> full_o=1, s_ready_o=0, count_o=32, almost_full_o=1 from count 31; 33rd write ignored.
REQ-033 Drain same FIFO with m_ready_i=1 -> data_o 0x00..0x1F in order, empty_o=1 after 32 reads, extra reads ignored.
REQ-034 Write 0xA5 into empty FIFO at edge N -> m_valid_o=1, data_o=0xA5 in cycle N+1 (OUT_REG=0) and N+2 (OUT_REG=1).
REQ-035 Count at 16, s_valid_i=m_ready_i=1 for 100 cycles with incrementing data -> count_o stays 16, output sequence contiguous across wrap.
REQ-036 Full FIFO, assert rst_n=0 one cycle -> count_o=0, empty_o=1, m_valid_o=0; next write 0x3C read back as 0x3C.
REQ-037 SYNC_FIFO_FLUSH_EN defined, count 10, flush_i=1 with s_valid_i=1 -> count_o=0 next cycle, written word discarded.
